mrd_pingpong_sched: RTL and testbench

- Packet-level ping-pong scheduler in front of two memory engines (engine 0, engine 1) of the Mixed Radix DFT core.
- Routes each input packet whole to one idle engine, and records completed-input order in a small order FIFO.
- Merges the two engine output streams back into one stream in that packet order, so engines may overlap Sink/Rd/Source phases without reordering packets.

---
 rtl/mrd_pingpong_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_mrd_pingpong_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_pingpong_sched.sv
// mrd_pingpong_sched
// Packet-level ping-pong scheduler sitting in front of the two memory engines
// of the Mixed Radix DFT core. Each input packet is steered whole to one idle
// engine; the engine index is recorded in a small order FIFO when the packet's
// last beat has been forwarded. The two engine output streams are merged back
// into a single stream in that recorded order. Output beats that arrive out of
// order are discarded and flagged.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_sop/in_eop         input stream qualifiers
//   in_real/in_imag                input sample (wDATA bits each)
//   in_size                        DFT size index, sampled on the sop beat
//   in_ready                       a new packet sop can be accepted
//   e_sink_ready[1:0]              per-engine idle/ready
//   e_valid/e_sop/e_eop[1:0]       per-engine gated stream qualifiers
//   e_real/e_imag/e_size           sample and size broadcast to both engines
//   eo_valid/eo_sop/eo_eop[1:0]    per-engine output qualifiers
//   eo_real/eo_imag/eo_exp         engine outputs, engine i in slice i
//   out_valid/out_sop/out_eop      merged output qualifiers
//   out_real/out_imag/out_exp      merged output sample and block exponent
//   out_eng                        engine that produced the current beat
//   err_order                      pulse: an engine output beat was discarded
//   err_timeout                    pulse: an input packet was abandoned

module mrd_pingpong_sched #(
  parameter int wDATA     = 18,
  parameter int wEXP      = 4,
  parameter int ORD_DEPTH = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic                in_eop,
  input  logic [wDATA-1:0]    in_real,
  input  logic [wDATA-1:0]    in_imag,
  input  logic [5:0]          in_size,
  output logic                in_ready,
  input  logic [1:0]          e_sink_ready,
  output logic [1:0]          e_valid,
  output logic [1:0]          e_sop,
  output logic [1:0]          e_eop,
  output logic [wDATA-1:0]    e_real,
  output logic [wDATA-1:0]    e_imag,
  output logic [5:0]          e_size,
  input  logic [1:0]          eo_valid,
  input  logic [1:0]          eo_sop,
  input  logic [1:0]          eo_eop,
  input  logic [2*wDATA-1:0]  eo_real,
  input  logic [2*wDATA-1:0]  eo_imag,
  input  logic [2*wEXP-1:0]   eo_exp,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  output logic [wDATA-1:0]    out_real,
  output logic [wDATA-1:0]    out_imag,
  output logic [wEXP-1:0]     out_exp,
  output logic                out_eng,
  output logic                err_order,
  output logic                err_timeout
);

  localparam int PW = $clog2(ORD_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RT0, RT1} state_t;

  state_t          state, state_nxt;
  logic            pref;
  logic [TW-1:0]   to_cnt;

  logic            tgt_ok, tgt;
  logic            fwd, fwd_sop, fwd_eng, push, to_hit;

  logic [ORD_DEPTH-1:0] ord_mem;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   ord_cnt;
  logic            fifo_ne, head, pass, pop, stray;

  // Target engine: the preferred one if it is ready, otherwise the other one.
  // NOTE: every signal written in an always_comb gets a default at the top so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tgt_ok = 1'b1;
    tgt    = pref;
    if (e_sink_ready[pref]) begin
      tgt = pref;
    end else if (e_sink_ready[~pref]) begin
      tgt = ~pref;
    end else begin
      tgt_ok = 1'b0;
    end
  end

  // Gated by rst so that every output reads 0 while reset is held.
  assign in_ready = (state == IDLE) && tgt_ok && (ord_cnt < CW'(ORD_DEPTH)) && !rst;

  // Input FSM: next state and per-beat forwarding controls.
  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    fwd_sop   = 1'b0;
    fwd_eng   = 1'b0;
    push      = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        fwd_eng = tgt;
        if (in_valid && in_sop && in_ready) begin
          fwd     = 1'b1;
          fwd_sop = 1'b1;
          if (in_eop) push = 1'b1;                  // single-beat packet
          else        state_nxt = tgt ? RT1 : RT0;
        end
      end
      RT0, RT1: begin
        fwd_eng = (state == RT1);
        if (in_valid) begin
          fwd = 1'b1;                               // a stray sop is plain data here
          if (in_eop) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input side registers: FSM, preference, timeout counter, engine interface.
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pref        <= 1'b0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
      e_valid     <= '0;
      e_sop       <= '0;
      e_eop       <= '0;
      e_real      <= '0;
      e_imag      <= '0;
      e_size      <= '0;
    end else begin
      state       <= state_nxt;
      err_timeout <= to_hit;
      if (fwd_sop) pref <= ~tgt;
      if (state == IDLE || in_valid || to_hit) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + TW'(1);
      e_valid <= '0;
      e_sop   <= '0;
      e_eop   <= '0;
      if (fwd) begin
        e_valid[fwd_eng] <= 1'b1;
        e_sop[fwd_eng]   <= fwd_sop;
        e_eop[fwd_eng]   <= in_eop;
        e_real           <= in_real;
        e_imag           <= in_imag;
        if (fwd_sop) e_size <= in_size;             // held for the whole packet
      end
    end
  end

  // Order FIFO control. The head is only consulted when the FIFO is non-empty.
  assign fifo_ne = (ord_cnt != '0);
  assign head    = ord_mem[rd_ptr];
  assign pass    = fifo_ne && eo_valid[head];
  assign pop     = pass && eo_eop[head];
  assign stray   = fifo_ne ? eo_valid[~head] : |eo_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ord_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   ord_cnt <= ord_cnt + CW'(1);
        2'b01:   ord_cnt <= ord_cnt - CW'(1);
        default: ord_cnt <= ord_cnt;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and count are reset and
  // an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) ord_mem[wr_ptr] <= fwd_eng;
  end

  // Output merge: pass the head engine's beat, discard anything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_exp   <= '0;
      out_eng   <= 1'b0;
      err_order <= 1'b0;
    end else begin
      out_valid <= pass;
      out_sop   <= pass && eo_sop[head];
      out_eop   <= pop;
      err_order <= stray;
      if (pass) begin
        out_real <= head ? eo_real[2*wDATA-1:wDATA] : eo_real[wDATA-1:0];
        out_imag <= head ? eo_imag[2*wDATA-1:wDATA] : eo_imag[wDATA-1:0];
        out_exp  <= head ? eo_exp[2*wEXP-1:wEXP]    : eo_exp[wEXP-1:0];
        out_eng  <= head;
      end
    end
  end

endmodule

// File: tb/tb_mrd_pingpong_sched.sv
// Directed bench for mrd_pingpong_sched. Each cycle the bench drives inputs
// on the falling edge, pushes the expected registered response into a
// scoreboard queue, and pops/compares it one falling edge later.

module tb_mrd_pingpong_sched;

  localparam int W  = 18;
  localparam int WE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_sop, in_eop;
  logic [W-1:0]    in_real, in_imag;
  logic [5:0]      in_size;
  logic            in_ready;
  logic [1:0]      e_sink_ready;
  logic [1:0]      e_valid, e_sop, e_eop;
  logic [W-1:0]    e_real, e_imag;
  logic [5:0]      e_size;
  logic [1:0]      eo_valid, eo_sop, eo_eop;
  logic [2*W-1:0]  eo_real, eo_imag;
  logic [2*WE-1:0] eo_exp;
  logic            out_valid, out_sop, out_eop;
  logic [W-1:0]    out_real, out_imag;
  logic [WE-1:0]   out_exp;
  logic            out_eng, err_order, err_timeout;

  always #5 clk = ~clk;

  mrd_pingpong_sched #(.wDATA(W), .wEXP(WE), .ORD_DEPTH(4), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_real(in_real), .in_imag(in_imag), .in_size(in_size),
    .in_ready(in_ready), .e_sink_ready(e_sink_ready),
    .e_valid(e_valid), .e_sop(e_sop), .e_eop(e_eop),
    .e_real(e_real), .e_imag(e_imag), .e_size(e_size),
    .eo_valid(eo_valid), .eo_sop(eo_sop), .eo_eop(eo_eop),
    .eo_real(eo_real), .eo_imag(eo_imag), .eo_exp(eo_exp),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag), .out_exp(out_exp),
    .out_eng(out_eng), .err_order(err_order), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [1:0] v, s, e;
    logic [W-1:0] re, im;
    logic [5:0] sz;
  } e_rec_t;

  typedef struct packed {
    logic v, s, e;
    logic [W-1:0] re, im;
    logic [WE-1:0] ex;
    logic eng, eord, eto;
  } o_rec_t;

  e_rec_t e_q[$];
  o_rec_t o_q[$];
  e_rec_t xe;
  o_rec_t xo;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    eo_valid = '0;   eo_sop = '0;   eo_eop = '0;
    xe = '0;
    xo = '0;
  endtask

  // One clock: queue expectation, clock, compare the registered response.
  task automatic cycle();
    e_rec_t ge;
    o_rec_t go;
    e_q.push_back(xe);
    o_q.push_back(xo);
    @(posedge clk);
    @(negedge clk);
    ge = e_q.pop_front();
    go = o_q.pop_front();
    check("e_valid", e_valid, ge.v);
    check("e_sop", e_sop, ge.s);
    check("e_eop", e_eop, ge.e);
    if (|ge.v) begin
      check("e_real", e_real, ge.re);
      check("e_imag", e_imag, ge.im);
      check("e_size", e_size, ge.sz);
    end
    check("out_valid", out_valid, go.v);
    check("out_sop", out_sop, go.s);
    check("out_eop", out_eop, go.e);
    check("err_order", err_order, go.eord);
    check("err_timeout", err_timeout, go.eto);
    if (go.v) begin
      check("out_real", out_real, go.re);
      check("out_imag", out_imag, go.im);
      check("out_exp", out_exp, go.ex);
      check("out_eng", out_eng, go.eng);
    end
    clear_stim();
  endtask

  // Whole input packet, expected on engine eng. in_size changes after sop
  // so that e_size must hold the sop value.
  task automatic send_pkt(input int eng, input int len, input logic [5:0] sz, input logic [W-1:0] base);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == len - 1);
      in_real  = base + W'(i);
      in_imag  = ~(base + W'(i));
      in_size  = (i == 0) ? sz : sz + 6'd1;
      xe.v[eng] = 1'b1;
      xe.s[eng] = (i == 0);
      xe.e[eng] = (i == len - 1);
      xe.re     = base + W'(i);
      xe.im     = ~(base + W'(i));
      xe.sz     = sz;
      cycle();
    end
  endtask

  // Drive one engine output beat; the idle engine's slice gets garbage.
  task automatic eo_drive(input int eng, input logic sop, input logic eop,
                          input logic [W-1:0] re, input logic [WE-1:0] ex);
    if (eng == 0) begin
      eo_valid[0] = 1'b1; eo_sop[0] = sop; eo_eop[0] = eop;
      eo_real[W-1:0] = re; eo_imag[W-1:0] = ~re; eo_exp[WE-1:0] = ex;
      if (!eo_valid[1]) begin
        eo_real[2*W-1:W] = re ^ 18'h2aaaa; eo_imag[2*W-1:W] = re ^ 18'h15555;
        eo_exp[2*WE-1:WE] = ~ex;
      end
    end else begin
      eo_valid[1] = 1'b1; eo_sop[1] = sop; eo_eop[1] = eop;
      eo_real[2*W-1:W] = re; eo_imag[2*W-1:W] = ~re; eo_exp[2*WE-1:WE] = ex;
      if (!eo_valid[0]) begin
        eo_real[W-1:0] = re ^ 18'h2aaaa; eo_imag[W-1:0] = re ^ 18'h15555;
        eo_exp[WE-1:0] = ~ex;
      end
    end
  endtask

  // Engine output packet; passes to out_* or is discarded with err_order.
  task automatic recv_pkt(input int eng, input int len, input logic [W-1:0] base,
                          input logic [WE-1:0] ex, input logic pass);
    for (int i = 0; i < len; i++) begin
      eo_drive(eng, (i == 0), (i == len - 1), base + W'(i), ex);
      if (pass) begin
        xo.v = 1'b1; xo.s = (i == 0); xo.e = (i == len - 1);
        xo.re = base + W'(i); xo.im = ~(base + W'(i)); xo.ex = ex;
        xo.eng = (eng == 1);
      end else begin
        xo.eord = 1'b1;
      end
      cycle();
    end
  endtask

  task automatic ready_is(input logic [1:0] sink, input logic exp, input string tag);
    e_sink_ready = sink;
    #1;
    check(tag, in_ready, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected end before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    e_sink_ready = 2'b11;
    clear_stim();
    in_real = '0; in_imag = '0; in_size = '0;
    eo_real = '0; eo_imag = '0; eo_exp = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst in_ready", in_ready, 1'b0);
    check("rst e_valid", e_valid, 2'b00);
    check("rst e_size", e_size, 6'd0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_real", out_real, '0);
    check("rst out_eng", out_eng, 1'b0);
    check("rst err_order", err_order, 1'b0);
    check("rst err_timeout", err_timeout, 1'b0);
    rst = 1'b0;
    ready_is(2'b11, 1'b1, "idle in_ready");

    // Ping-pong: A to engine 0, B to engine 1
    send_pkt(0, 12, 6'd5, 18'h100);
    ready_is(2'b11, 1'b1, "after A in_ready");
    send_pkt(1, 4, 6'd9, 18'h200);

    // B returned first is discarded; A then B pass in order
    recv_pkt(1, 4, 18'h300, 4'h3, 1'b0);
    recv_pkt(0, 12, 18'h400, 4'h5, 1'b1);
    recv_pkt(1, 4, 18'h500, 4'h6, 1'b1);
    recv_pkt(0, 1, 18'h600, 4'h1, 1'b0);          // FIFO empty
    check("out_real hold", out_real, 18'h503);
    check("out_exp hold", out_exp, 4'h6);

    // Only engine 1 ready with pref=0
    ready_is(2'b10, 1'b1, "eng1 only in_ready");
    send_pkt(1, 3, 6'd7, 18'h700);
    ready_is(2'b00, 1'b0, "none ready in_ready");
    in_valid = 1'b1; in_sop = 1'b1; in_real = 18'h7f0; in_size = 6'd8;
    cycle();                                       // dropped sop
    e_sink_ready = 2'b11;
    in_valid = 1'b1; in_real = 18'h7f1;
    cycle();                                       // dropped data beat
    ready_is(2'b11, 1'b1, "still idle in_ready");
    recv_pkt(1, 3, 18'h800, 4'h2, 1'b1);

    // Fill the order FIFO
    send_pkt(0, 1, 6'd1, 18'h900);
    send_pkt(1, 1, 6'd2, 18'h910);
    send_pkt(0, 1, 6'd3, 18'h920);
    send_pkt(1, 1, 6'd4, 18'h930);
    check("full in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_real = 18'h9f0;
    cycle();                                       // dropped while full
    recv_pkt(0, 1, 18'ha00, 4'h7, 1'b1);
    check("after pop in_ready", in_ready, 1'b1);

    // Push and pop in the same cycle, plus a non-head beat discarded
    in_valid = 1'b1; in_sop = 1'b1; in_real = 18'hb00; in_imag = ~18'hb00; in_size = 6'd10;
    xe.v[0] = 1'b1; xe.s[0] = 1'b1; xe.re = 18'hb00; xe.im = ~18'hb00; xe.sz = 6'd10;
    cycle();
    in_valid = 1'b1; in_eop = 1'b1; in_real = 18'hb01; in_imag = ~18'hb01; in_size = 6'd11;
    xe.v[0] = 1'b1; xe.e[0] = 1'b1; xe.re = 18'hb01; xe.im = ~18'hb01; xe.sz = 6'd10;
    eo_drive(1, 1'b1, 1'b1, 18'hc00, 4'h8);
    eo_drive(0, 1'b1, 1'b1, 18'hc10, 4'h9);
    xo.v = 1'b1; xo.s = 1'b1; xo.e = 1'b1; xo.re = 18'hc00; xo.im = ~18'hc00;
    xo.ex = 4'h8; xo.eng = 1'b1; xo.eord = 1'b1;
    cycle();
    check("push+pop in_ready", in_ready, 1'b1);
    send_pkt(1, 1, 6'd12, 18'hd00);
    check("refull in_ready", in_ready, 1'b0);
    recv_pkt(0, 1, 18'he00, 4'ha, 1'b1);
    recv_pkt(1, 1, 18'he10, 4'hb, 1'b1);
    recv_pkt(0, 1, 18'he20, 4'hc, 1'b1);
    recv_pkt(1, 1, 18'he30, 4'hd, 1'b1);
    check("drained in_ready", in_ready, 1'b1);

    // Timeout: counter clears on a mid-packet beat, then 4096 idle cycles
    in_valid = 1'b1; in_sop = 1'b1; in_real = 18'hf00; in_imag = ~18'hf00; in_size = 6'd20;
    xe.v[0] = 1'b1; xe.s[0] = 1'b1; xe.re = 18'hf00; xe.im = ~18'hf00; xe.sz = 6'd20;
    cycle();
    repeat (100) cycle();
    check("in packet in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_real = 18'hf01; in_imag = ~18'hf01; in_size = 6'd21;
    xe.v[0] = 1'b1; xe.re = 18'hf01; xe.im = ~18'hf01; xe.sz = 6'd20;
    cycle();
    for (int n = 1; n <= 4096; n++) begin
      if (n == 4096) xo.eto = 1'b1;
      cycle();
    end
    cycle();                                       // pulse lasts one cycle
    check("timeout in_ready", in_ready, 1'b1);
    recv_pkt(0, 1, 18'h111, 4'h1, 1'b0);          // no push happened
    send_pkt(1, 2, 6'd21, 18'h120);

    // Reset mid-packet in RT0
    in_valid = 1'b1; in_sop = 1'b1; in_real = 18'h130; in_imag = ~18'h130; in_size = 6'd22;
    xe.v[0] = 1'b1; xe.s[0] = 1'b1; xe.re = 18'h130; xe.im = ~18'h130; xe.sz = 6'd22;
    cycle();
    in_valid = 1'b1; in_real = 18'h131;
    #2 rst = 1'b1;
    #1;
    check("midrst e_valid", e_valid, 2'b00);
    check("midrst e_real", e_real, '0);
    check("midrst e_size", e_size, 6'd0);
    check("midrst out_real", out_real, '0);
    check("midrst out_eng", out_eng, 1'b0);
    check("midrst in_ready", in_ready, 1'b0);
    clear_stim();
    @(negedge clk);
    rst = 1'b0;
    ready_is(2'b00, 1'b0, "post rst none in_ready");
    ready_is(2'b01, 1'b1, "post rst eng0 in_ready");
    recv_pkt(1, 1, 18'h140, 4'h2, 1'b0);          // FIFO was cleared
    in_valid = 1'b1; in_real = 18'h141;
    cycle();                                       // FSM idle: dropped
    send_pkt(0, 2, 6'd3, 18'h150);
    recv_pkt(0, 2, 18'h160, 4'h3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
